// File: rtl/vga_sync_timing_generator_if.sv
// rtl/vga_sync_timing_generator_if.sv - VGA raster timing outputs bundle
interface vga_sync_timing_generator_if;
  logic       blank_n;
  logic       HS;
  logic       VS;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       line_start;
  logic       frame_start;

  modport master (
    output blank_n, HS, VS, pix_x, pix_y, line_start, frame_start
  );

  modport slave (
    input blank_n, HS, VS, pix_x, pix_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_sync_timing_generator.sv
// rtl/vga_sync_timing_generator.sv - free-running VGA raster counters with combinational sync/blank decode
module vga_sync_timing_generator #(
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 144,
  parameter int H_FRONT = 16,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 34,
  parameter int V_FRONT = 11
) (
  input  logic                         vga_clk,
  input  logic                         reset,
  vga_sync_timing_generator_if.master  vga
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] H_BACK_C = 10'(H_BACK);
  localparam logic [9:0] H_END_C  = 10'(H_TOTAL - H_FRONT);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] V_BACK_C = 10'(V_BACK);
  localparam logic [9:0] V_END_C  = 10'(V_TOTAL - V_FRONT);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_active;
  logic       v_active;
  logic       active;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Outputs decode the counter registers directly; downstream adds its own alignment.
  assign h_active = (h_cnt_q >= H_BACK_C) && (h_cnt_q < H_END_C);
  assign v_active = (v_cnt_q >= V_BACK_C) && (v_cnt_q < V_END_C);
  assign active   = h_active && v_active;

  assign vga.HS          = (h_cnt_q >= H_SYNC_C);
  assign vga.VS          = (v_cnt_q >= V_SYNC_C);
  assign vga.blank_n     = active;
  assign vga.pix_x       = active ? (h_cnt_q - H_BACK_C) : '0;
  assign vga.pix_y       = active ? 9'(v_cnt_q - V_BACK_C) : '0;
  assign vga.line_start  = (h_cnt_q == '0);
  assign vga.frame_start = (h_cnt_q == H_BACK_C) && (v_cnt_q == V_BACK_C);

endmodule

// File: tb/tb_vga_sync_timing_generator.sv
// tb/tb_vga_sync_timing_generator.sv - directed bench for the VGA timing generator
module tb_vga_sync_timing_generator;

  logic clk = 1'b0;
  logic ra  = 1'b1;
  logic rb  = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vga_sync_timing_generator_if a ();
  vga_sync_timing_generator_if b ();

  vga_sync_timing_generator dut_a (
    .vga_clk (clk),
    .reset   (ra),
    .vga     (a)
  );

  // Shrunk raster: 40 clocks/line, 20 lines/frame, active 26 x 12.
  vga_sync_timing_generator #(
    .H_TOTAL(40), .H_SYNC(6), .H_BACK(10), .H_FRONT(4),
    .V_TOTAL(20), .V_SYNC(2), .V_BACK(5),  .V_FRONT(3)
  ) dut_b (
    .vga_clk (clk),
    .reset   (rb),
    .vga     (b)
  );

  task automatic test_reset();
    ra = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({a.HS, a.VS, a.blank_n, a.line_start, a.frame_start} !== 5'b00010) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, expected 00010", {a.HS, a.VS, a.blank_n, a.line_start, a.frame_start});
    end
    vectors++;
    if (a.pix_x !== 10'd0 || a.pix_y !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_pix: got %0d,%0d, expected 0,0", a.pix_x, a.pix_y);
    end
    ra = 1'b0;
    repeat (95) @(negedge clk);
    vectors++;
    if (a.HS !== 1'b0 || a.line_start !== 1'b0) begin
      miscompares++;
      $display("FAIL hs_at_95: got HS=%b ls=%b, expected HS=0 ls=0", a.HS, a.line_start);
    end
    @(negedge clk);
    vectors++;
    if (a.HS !== 1'b1) begin
      miscompares++;
      $display("FAIL hs_at_96: got %b, expected 1", a.HS);
    end
  endtask

  task automatic test_line_timing();
    int hs_low = 0, ls_cnt = 0, ls_bad = 0, vs_low = 0, blank_hi = 0;
    ra = 1'b1;
    @(negedge clk);
    ra = 1'b0;
    for (int c = 0; c < 1600; c++) begin
      if (!a.HS) hs_low++;
      if (a.line_start) begin
        ls_cnt++;
        if (c % 800 != 0) ls_bad++;
      end
      if (!a.VS) vs_low++;
      if (a.blank_n) blank_hi++;
      @(negedge clk);
    end
    vectors++;
    if (hs_low != 192) begin
      miscompares++;
      $display("FAIL hs_low_count: got %0d, expected 192", hs_low);
    end
    vectors++;
    if (ls_cnt != 2 || ls_bad != 0) begin
      miscompares++;
      $display("FAIL line_start_period: got %0d pulses %0d misplaced, expected 2 and 0", ls_cnt, ls_bad);
    end
    vectors++;
    if (vs_low != 1600) begin
      miscompares++;
      $display("FAIL vs_low_lines01: got %0d, expected 1600", vs_low);
    end
    vectors++;
    if (blank_hi != 0) begin
      miscompares++;
      $display("FAIL blank_in_sync_lines: got %0d, expected 0", blank_hi);
    end
    vectors++;
    if (a.VS !== 1'b1 || a.line_start !== 1'b1) begin
      miscompares++;
      $display("FAIL vs_rise_line2: got VS=%b ls=%b, expected VS=1 ls=1", a.VS, a.line_start);
    end
  endtask

  task automatic test_coordinates();
    int run = 0;
    repeat (27343 - 1600) @(negedge clk);
    vectors++;
    if (a.blank_n !== 1'b0 || a.frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL h143_v34: got blank=%b fs=%b, expected 0 0", a.blank_n, a.frame_start);
    end
    @(negedge clk);
    vectors++;
    if ({a.frame_start, a.blank_n} !== 2'b11 || a.pix_x !== 10'd0 || a.pix_y !== 9'd0) begin
      miscompares++;
      $display("FAIL first_pixel: got fs=%b blank=%b x=%0d y=%0d, expected 1 1 0 0", a.frame_start, a.blank_n, a.pix_x, a.pix_y);
    end
    for (int i = 0; i < 640; i++) begin
      if (a.blank_n) run++;
      if (i == 639) begin
        vectors++;
        if (a.pix_x !== 10'd639 || a.pix_y !== 9'd0) begin
          miscompares++;
          $display("FAIL last_col: got x=%0d y=%0d, expected 639 0", a.pix_x, a.pix_y);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (run != 640) begin
      miscompares++;
      $display("FAIL active_run: got %0d, expected 640", run);
    end
    vectors++;
    if (a.blank_n !== 1'b0 || a.pix_x !== 10'd0) begin
      miscompares++;
      $display("FAIL h784: got blank=%b x=%0d, expected 0 0", a.blank_n, a.pix_x);
    end
  endtask

  task automatic test_mid_frame_reset();
    int first = -1;
    repeat (416) @(negedge clk);
    vectors++;
    if (a.blank_n !== 1'b1 || a.pix_x !== 10'd256 || a.pix_y !== 9'd1) begin
      miscompares++;
      $display("FAIL pre_reset_pos: got blank=%b x=%0d y=%0d, expected 1 256 1", a.blank_n, a.pix_x, a.pix_y);
    end
    ra = 1'b1;
    @(negedge clk);
    vectors++;
    if ({a.HS, a.VS, a.blank_n, a.line_start, a.frame_start} !== 5'b00010 || a.pix_x !== 10'd0) begin
      miscompares++;
      $display("FAIL mid_reset_decode: got %b x=%0d, expected 00010 x=0", {a.HS, a.VS, a.blank_n, a.line_start, a.frame_start}, a.pix_x);
    end
    ra = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      if (a.frame_start) begin
        first = c;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (first != 27344) begin
      miscompares++;
      $display("FAIL frame_start_after_reset: got %0d, expected 27344", first);
    end
  endtask

  task automatic test_small_frame();
    int vs_low = 0, blank_hi = 0, ls_cnt = 0, fs_cnt = 0, fs_pos = -1;
    int runs = 0, cur = 0, max_run = 0;
    logic prev = 1'b0;
    rb = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({b.HS, b.VS, b.blank_n, b.line_start} !== 4'b0001) begin
      miscompares++;
      $display("FAIL small_reset: got %b, expected 0001", {b.HS, b.VS, b.blank_n, b.line_start});
    end
    rb = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!b.VS) vs_low++;
      if (b.line_start) ls_cnt++;
      if (b.frame_start) begin
        fs_cnt++;
        fs_pos = c;
      end
      if (b.blank_n) begin
        blank_hi++;
        cur++;
        if (!prev) runs++;
        if (cur > max_run) max_run = cur;
      end else begin
        cur = 0;
      end
      prev = b.blank_n;
      if (c == 675) begin
        vectors++;
        if (b.pix_x !== 10'd25 || b.pix_y !== 9'd11 || b.blank_n !== 1'b1) begin
          miscompares++;
          $display("FAIL small_last_pixel: got x=%0d y=%0d blank=%b, expected 25 11 1", b.pix_x, b.pix_y, b.blank_n);
        end
      end
      if (c == 676) begin
        vectors++;
        if (b.blank_n !== 1'b0 || b.pix_x !== 10'd0 || b.pix_y !== 9'd0) begin
          miscompares++;
          $display("FAIL small_after_last: got blank=%b x=%0d y=%0d, expected 0 0 0", b.blank_n, b.pix_x, b.pix_y);
        end
      end
      if (c == 799) begin
        vectors++;
        if (b.VS !== 1'b1) begin
          miscompares++;
          $display("FAIL small_vs_end: got %b, expected 1", b.VS);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (vs_low != 80) begin
      miscompares++;
      $display("FAIL small_vs_low: got %0d, expected 80", vs_low);
    end
    vectors++;
    if (blank_hi != 312 || runs != 12 || max_run != 26) begin
      miscompares++;
      $display("FAIL small_active: got %0d clocks %0d runs max %0d, expected 312 12 26", blank_hi, runs, max_run);
    end
    vectors++;
    if (ls_cnt != 20) begin
      miscompares++;
      $display("FAIL small_line_starts: got %0d, expected 20", ls_cnt);
    end
    vectors++;
    if (fs_cnt != 1 || fs_pos != 210) begin
      miscompares++;
      $display("FAIL small_frame_start: got %0d pulses at %0d, expected 1 at 210", fs_cnt, fs_pos);
    end
    vectors++;
    if (b.VS !== 1'b0 || b.line_start !== 1'b1) begin
      miscompares++;
      $display("FAIL small_vs_wrap: got VS=%b ls=%b, expected 0 1", b.VS, b.line_start);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_line_timing();
    test_coordinates();
    test_mid_frame_reset();
    test_small_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_timing_generator.md
Name: vga_sync_timing_generator

Overview:
- Free-running 640x480 VGA raster timing generator, driven from the pixel clock.
- Produces active-low horizontal and vertical sync, an active-high display-enable (blank_n), pixel coordinates and frame and line markers.
- Feeds the VGA controller's frame-buffer address generator and colour pipeline, which adds its own output alignment delay.

Parameters:
- H_TOTAL, 800, pixel clocks per line.
- H_SYNC, 96, HS low width in clocks, starting at h=0.
- H_BACK, 144, first active column (sync plus back porch).
- H_FRONT, 16, front-porch clocks at end of line.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, VS low width in lines, starting at v=0.
- V_BACK, 34, first active line.
- V_FRONT, 11, front-porch lines at end of frame.

Ports:
- vga_clk  input  1  pixel clock; single clock domain, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- blank_n  output  1  high while in the active display area.
- HS  output  1  horizontal sync, active low.
- VS  output  1  vertical sync, active low.
- pix_x  output  10  active column 0..639; 0 outside the active area.
- pix_y  output  9  active row 0..479; 0 outside the active area.
- line_start  output  1  one-clock pulse at h=0 of every line.
- frame_start  output  1  one-clock pulse at the first active pixel (h=H_BACK, v=V_BACK).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are vga_clk and reset.
- Internal counters:
  - h_cnt is 10 bits, v_cnt is 10 bits.
  - While reset is high at a rising edge, h_cnt and v_cnt are set to 0.
- Horizontal counter: each non-reset rising edge, h_cnt increments; at H_TOTAL-1 (799) it wraps to 0.
- Vertical counter:
  - v_cnt increments only on an edge where h_cnt == H_TOTAL-1.
  - If v_cnt == V_TOTAL-1 (524) on that edge, it wraps to 0.
  - Otherwise v_cnt holds.
- Outputs are a pure combinational decode of the counter registers. There is no extra pipeline stage; outputs change in the same cycle the counters do.
- HS = 0 when h_cnt < H_SYNC (0..95), else 1.
- VS = 0 when v_cnt < V_SYNC (0..1), else 1. VS changes aligned with h_cnt = 0.
- blank_n = 1 iff H_BACK <= h_cnt < H_TOTAL-H_FRONT and V_BACK <= v_cnt < V_TOTAL-V_FRONT.
  - This is h 144..783 and v 34..513.
  - Exactly 640 x 480 = 307200 active clocks per frame.
- pix_x = h_cnt-H_BACK and pix_y = v_cnt-V_BACK when blank_n = 1; both are 0 otherwise.
- line_start = 1 iff h_cnt == 0.
- frame_start = 1 iff h_cnt == H_BACK and v_cnt == V_BACK.
- Output values during and immediately after reset follow the decode of (0,0): HS=0, VS=0, blank_n=0, pix_x=0, pix_y=0, line_start=1, frame_start=0.
- HS=0 and VS=0 together occur only in lines 0..1, columns 0..95. Downstream uses this as the frame-address reset window.
- Reset asserted mid-frame: counters return to (0,0) on that edge; there is no partial-line completion.
- Arithmetic:
  - All comparisons are unsigned.
  - Parameter constraints: H_SYNC < H_BACK < H_TOTAL-H_FRONT, and the same ordering for the vertical parameters.
  - Counter widths must hold H_TOTAL-1 and V_TOTAL-1.
- Timing: frame period is 800*525 = 420000 clocks, so 60 Hz at a 25.2 MHz pixel clock.

Test Plan:
- Reset: hold reset 3 cycles, then release.
  - Required during reset: HS=0, VS=0, blank_n=0, line_start=1.
  - Required after release: h_cnt reaches 95 at clock 95 with HS=0; HS=1 at clock 96.
- Line timing: measure from reset release.
  - HS low exactly 96 clocks per 800-clock period.
  - line_start pulses every 800 clocks.
- Frame timing:
  - VS low exactly 2*800 = 1600 clocks per 420000-clock frame.
  - VS falls on the same clock that line_start pulses after v wraps from 524.
- Active area:
  - blank_n is high for 640 consecutive clocks per active line and for exactly 480 lines per frame (lines 34..513).
  - Total high count per frame is 307200.
- Coordinates:
  - At h=144, v=34: pix_x=0, pix_y=0, frame_start=1.
  - At h=783, v=513: pix_x=639, pix_y=479.
  - At h=784: blank_n=0 and pix_x=0.
- Mid-frame reset: assert reset at v=200, h=400 for 1 cycle.
  - Next cycle shows the (0,0) decode.
  - The following frame_start occurs exactly 34*800+144 = 27344 clocks after reset release.
